// File: rtl/simon_pkg.sv
// Shared definitions for the Simon score display: 7-segment digit codes,
// score limits and state typedefs used by the converter and the top level.
package simon_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] MAX_SCORE = 7'd99;
  localparam int         CONV_BITS = 7;

  // Segment order is {g,f,e,d,c,b,a}, active-high before polarity inversion.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic {
    CONV_IDLE = 1'b0,
    CONV_RUN  = 1'b1
  } conv_state_t;

  typedef enum logic {
    SLOT_TENS = 1'b0,
    SLOT_ONES = 1'b1
  } slot_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/simon_score_display_if.sv
// Score-in / display-out bundle between the game core and the display stage.
interface simon_score_display_if;
  import simon_pkg::*;

  // score_load is a one-cycle strobe with no back-pressure: it is always
  // accepted, and a load while busy=1 restarts the conversion (last wins).
  logic [6:0]  score_in;
  logic        score_load;
  logic        seginv;
  logic        blank;
  logic [6:0]  seg;
  logic        dig1;
  logic        dig2;
  logic        busy;
  conv_state_t conv_state;

  modport master (
    output score_in, score_load, seginv, blank,
    input  seg, dig1, dig2, busy, conv_state
  );

  modport slave (
    input  score_in, score_load, seginv, blank,
    output seg, dig1, dig2, busy, conv_state
  );

endinterface

// File: rtl/simon_bin2bcd_seq.sv
// 7-bit sequential double-dabble: one shift-add-3 iteration per cycle.
// done/tens/ones are combinational on the cycle of the final iteration.
module simon_bin2bcd_seq
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  din,
  output logic        busy,
  output logic        done,
  output logic [3:0]  tens,
  output logic [3:0]  ones,
  output conv_state_t state
);

  conv_state_t state_q, state_d;
  logic [6:0]  sh_q, sh_d;
  logic [7:0]  bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  adj_tens, adj_ones;
  logic [7:0]  bcd_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tens never exceeds 9 for inputs up to 99, so the hundreds carry is dropped.
  always_comb begin
    adj_tens = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    adj_ones = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_step = 8'({adj_tens, adj_ones, sh_q[6]});
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (start) begin
      state_d = CONV_RUN;
      sh_d    = din;
      bcd_d   = '0;
      cnt_d   = '0;
    end else if (state_q == CONV_RUN) begin
      sh_d  = {sh_q[5:0], 1'b0};
      bcd_d = bcd_step;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'(CONV_BITS - 1)) begin
        done    = 1'b1;
        state_d = CONV_IDLE;
      end
    end
  end

  assign busy  = (state_q == CONV_RUN);
  assign tens  = bcd_step[7:4];
  assign ones  = bcd_step[3:0];
  assign state = state_q;

endmodule

// File: rtl/simon_score_display.sv
// Simon score display: clamp, BCD conversion, digit hold and two-digit
// multiplexed 7-segment drive. Define SIMON_SCORE_LZB_EN for leading-zero blanking.
module simon_score_display
  import simon_pkg::*;
#(
  parameter int REFRESH_DIV = 4096
)(
  input  logic                 clk,
  input  logic                 rst,
  simon_score_display_if.slave bus
);

  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

  logic [6:0]  score_clamped;
  logic        conv_busy;
  logic        conv_done;
  logic [3:0]  conv_tens;
  logic [3:0]  conv_ones;
  conv_state_t conv_state;

  logic [3:0]  hold_tens;
  logic [3:0]  hold_ones;
  logic [15:0] refresh_q;
  slot_t       slot_q;

  logic [6:0]  inv_mask;
  logic [6:0]  seg_d;
  logic        dig1_d;
  logic        dig2_d;

  assign score_clamped = (bus.score_in > MAX_SCORE) ? MAX_SCORE : bus.score_in;

  simon_bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (bus.score_load),
    .din   (score_clamped),
    .busy  (conv_busy),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones),
    .state (conv_state)
  );

  assign bus.busy       = conv_busy;
  assign bus.conv_state = conv_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_tens <= '0;
      hold_ones <= '0;
    end else if (conv_done) begin
      hold_tens <= conv_tens;
      hold_ones <= conv_ones;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      slot_q    <= SLOT_TENS;
    end else if (refresh_q == REFRESH_LAST) begin
      refresh_q <= '0;
      slot_q    <= (slot_q == SLOT_TENS) ? SLOT_ONES : SLOT_TENS;
    end else begin
      refresh_q <= refresh_q + 16'd1;
    end
  end

  // Count 0 of every slot is a dead cycle so the previous digit cannot ghost.
  always_comb begin
    inv_mask = {7{bus.seginv}};
    seg_d    = SEG_BLANK ^ inv_mask;
    dig1_d   = 1'b0;
    dig2_d   = 1'b0;
    if (!bus.blank && refresh_q != 16'd0) begin
      if (slot_q == SLOT_TENS) begin
`ifdef SIMON_SCORE_LZB_EN
        if (hold_tens != 4'd0) begin
          dig1_d = 1'b1;
          seg_d  = seg_encode(hold_tens) ^ inv_mask;
        end
`else
        dig1_d = 1'b1;
        seg_d  = seg_encode(hold_tens) ^ inv_mask;
`endif
      end else begin
        dig2_d = 1'b1;
        seg_d  = seg_encode(hold_ones) ^ inv_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.seg  <= SEG_BLANK ^ inv_mask;
      bus.dig1 <= 1'b0;
      bus.dig2 <= 1'b0;
    end else begin
      bus.seg  <= seg_d;
      bus.dig1 <= dig1_d;
      bus.dig2 <= dig2_d;
    end
  end

endmodule

// File: tb/tb_simon_score_display.sv
// Bench for simon_score_display: directed scenarios plus a random run, all
// checked against a cycle-count/arithmetic model of the display.
module tb_simon_score_display;

  localparam int RD = 4;
`ifdef SIMON_SCORE_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk;
  logic rst;
  simon_score_display_if bus();

  simon_score_display #(.REFRESH_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int vectors = 0;
  int miscompares = 0;

  // model state
  int   cyc = 0;
  int   pend_val = 0;
  int   pend_left = 0;
  int   hold_val = 0;
  logic [6:0] exp_seg = 7'h00;
  logic exp_dig1 = 1'b0;
  logic exp_dig2 = 1'b0;
  logic exp_busy = 1'b0;

  // Advances the model by one clock using the inputs currently applied,
  // then steps the clock and lands 1 time unit after the edge.
  task automatic tick();
    int cnt;
    int tens;
    int ones;
    bit ones_slot;
    logic [6:0] inv;
    inv = {7{bus.seginv}};
    if (rst) begin
      exp_seg   = inv;
      exp_dig1  = 1'b0;
      exp_dig2  = 1'b0;
      exp_busy  = 1'b0;
      hold_val  = 0;
      pend_left = 0;
      cyc       = 0;
    end else begin
      cnt       = cyc % RD;
      ones_slot = ((cyc / RD) % 2) == 1;
      tens      = hold_val / 10;
      ones      = hold_val % 10;
      exp_seg   = inv;
      exp_dig1  = 1'b0;
      exp_dig2  = 1'b0;
      if (!bus.blank && cnt != 0) begin
        if (!ones_slot) begin
          if (!LZB || tens != 0) begin
            exp_dig1 = 1'b1;
            exp_seg  = seg_tab[tens] ^ inv;
          end
        end else begin
          exp_dig2 = 1'b1;
          exp_seg  = seg_tab[ones] ^ inv;
        end
      end
      cyc++;
      if (bus.score_load) begin
        pend_val  = (bus.score_in > 7'd99) ? 99 : int'(bus.score_in);
        pend_left = 7;
      end else if (pend_left > 0) begin
        pend_left--;
        if (pend_left == 0) hold_val = pend_val;
      end
      exp_busy = (pend_left > 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.score_in = '0; bus.score_load = 1'b0; bus.seginv = 1'b0; bus.blank = 1'b0;
    tick();
    vectors++;
    if ({bus.seg, bus.dig1, bus.dig2, bus.busy} !== {7'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_plain: seg=%h d1=%b d2=%b busy=%b, want seg=00 d1=0 d2=0 busy=0",
               bus.seg, bus.dig1, bus.dig2, bus.busy);
    end
    bus.seginv = 1'b1;
    tick();
    vectors++;
    if ({bus.seg, bus.dig1, bus.dig2, bus.busy} !== {7'h7F, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_inv: seg=%h d1=%b d2=%b busy=%b, want seg=7f d1=0 d2=0 busy=0",
               bus.seg, bus.dig1, bus.dig2, bus.busy);
    end
    bus.seginv = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_load_42();
    int busy_cnt = 0;
    bit seen_tens = 0;
    bit seen_ones = 0;
    bus.score_in = 7'd42; bus.score_load = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      bus.score_load = 1'b0;
      busy_cnt += int'(bus.busy);
      if (bus.dig1 && bus.seg == 7'h66) seen_tens = 1;
      if (bus.dig2 && bus.seg == 7'h5B) seen_ones = 1;
      vectors++;
      if ({bus.seg, bus.dig1, bus.dig2, bus.busy} !== {exp_seg, exp_dig1, exp_dig2, exp_busy}) begin
        miscompares++;
        $display("FAIL load42 c%0d: got %h/%b%b/%b want %h/%b%b/%b", i, bus.seg, bus.dig1,
                 bus.dig2, bus.busy, exp_seg, exp_dig1, exp_dig2, exp_busy);
      end
    end
    vectors++;
    if (busy_cnt != 7 || !seen_tens || !seen_ones) begin
      miscompares++;
      $display("FAIL load42_summary: busy_cycles=%0d tens66=%b ones5b=%b, want 7 1 1",
               busy_cnt, seen_tens, seen_ones);
    end
  endtask

  task automatic test_clamp();
    logic [6:0] vals [2] = '{7'd123, 7'd99};
    for (int v = 0; v < 2; v++) begin
      bit seen_t = 0;
      bit seen_o = 0;
      bus.score_in = vals[v]; bus.score_load = 1'b1;
      for (int i = 0; i < 20; i++) begin
        tick();
        bus.score_load = 1'b0;
        if (bus.dig1 && bus.seg == 7'h6F) seen_t = 1;
        if (bus.dig2 && bus.seg == 7'h6F) seen_o = 1;
        vectors++;
        if ({bus.seg, bus.dig1, bus.dig2, bus.busy} !== {exp_seg, exp_dig1, exp_dig2, exp_busy}) begin
          miscompares++;
          $display("FAIL clamp%0d c%0d: got %h/%b%b/%b want %h/%b%b/%b", vals[v], i, bus.seg,
                   bus.dig1, bus.dig2, bus.busy, exp_seg, exp_dig1, exp_dig2, exp_busy);
        end
      end
      vectors++;
      if (!seen_t || !seen_o) begin
        miscompares++;
        $display("FAIL clamp%0d_nines: tens6f=%b ones6f=%b, want 1 1", vals[v], seen_t, seen_o);
      end
    end
  endtask

  task automatic test_seven();
    bit dig1_seen = 0;
    bit tens0_seen = 0;
    bit ones7_seen = 0;
    bus.score_in = 7'd7; bus.score_load = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      bus.score_load = 1'b0;
      if (i >= 8) begin
        if (bus.dig1) dig1_seen = 1;
        if (bus.dig1 && bus.seg == 7'h3F) tens0_seen = 1;
        if (bus.dig2 && bus.seg == 7'h07) ones7_seen = 1;
      end
      vectors++;
      if ({bus.seg, bus.dig1, bus.dig2, bus.busy} !== {exp_seg, exp_dig1, exp_dig2, exp_busy}) begin
        miscompares++;
        $display("FAIL seven c%0d: got %h/%b%b/%b want %h/%b%b/%b", i, bus.seg, bus.dig1,
                 bus.dig2, bus.busy, exp_seg, exp_dig1, exp_dig2, exp_busy);
      end
    end
    vectors++;
    if (dig1_seen !== !LZB || tens0_seen !== !LZB || !ones7_seen) begin
      miscompares++;
      $display("FAIL seven_digits: dig1=%b tens3f=%b ones07=%b, want %b %b 1",
               dig1_seen, tens0_seen, ones7_seen, !LZB, !LZB);
    end
  endtask

  task automatic test_back_to_back();
    bit saw_42 = 0;
    bit saw_5 = 0;
    bit saw_8 = 0;
    bus.score_in = 7'd42; bus.score_load = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) begin
        bus.score_in = 7'd58; bus.score_load = 1'b1;
      end
      tick();
      bus.score_load = 1'b0;
      if ((bus.dig1 && bus.seg == 7'h66) || (bus.dig2 && bus.seg == 7'h5B)) saw_42 = 1;
      if (bus.dig1 && bus.seg == 7'h6D) saw_5 = 1;
      if (bus.dig2 && bus.seg == 7'h7F) saw_8 = 1;
      vectors++;
      if ({bus.seg, bus.dig1, bus.dig2, bus.busy} !== {exp_seg, exp_dig1, exp_dig2, exp_busy}) begin
        miscompares++;
        $display("FAIL restart c%0d: got %h/%b%b/%b want %h/%b%b/%b", i, bus.seg, bus.dig1,
                 bus.dig2, bus.busy, exp_seg, exp_dig1, exp_dig2, exp_busy);
      end
    end
    vectors++;
    if (saw_42 || !saw_5 || !saw_8) begin
      miscompares++;
      $display("FAIL restart_digits: shown42=%b tens6d=%b ones7f=%b, want 0 1 1", saw_42, saw_5, saw_8);
    end
  endtask

  task automatic test_reset_and_blank();
    bus.score_in = 7'd63; bus.score_load = 1'b1;
    tick();
    bus.score_load = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus.seg, bus.dig1, bus.dig2, bus.busy} !== {7'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL rst_mid: seg=%h d1=%b d2=%b busy=%b, want seg=00 d1=0 d2=0 busy=0",
               bus.seg, bus.dig1, bus.dig2, bus.busy);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if ({bus.seg, bus.dig1, bus.dig2, bus.busy} !== {exp_seg, exp_dig1, exp_dig2, exp_busy}) begin
        miscompares++;
        $display("FAIL post_rst c%0d: got %h/%b%b/%b want %h/%b%b/%b", i, bus.seg, bus.dig1,
                 bus.dig2, bus.busy, exp_seg, exp_dig1, exp_dig2, exp_busy);
      end
    end
    bus.score_in = 7'd35; bus.score_load = 1'b1;
    tick();
    bus.score_load = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.blank = 1'b1; bus.seginv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({bus.seg, bus.dig1, bus.dig2} !== {7'h7F, 2'b00}) begin
        miscompares++;
        $display("FAIL blank_inv c%0d: seg=%h d1=%b d2=%b, want seg=7f d1=0 d2=0",
                 i, bus.seg, bus.dig1, bus.dig2);
      end
    end
    bus.blank = 1'b0; bus.seginv = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.score_load = ($urandom_range(0, 5) == 0);
      bus.score_in   = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 39) == 0) bus.seginv = ~bus.seginv;
      if ($urandom_range(0, 29) == 0) bus.blank = ~bus.blank;
      rst = ($urandom_range(0, 149) == 0);
      tick();
      vectors++;
      if ({bus.seg, bus.dig1, bus.dig2, bus.busy} !== {exp_seg, exp_dig1, exp_dig2, exp_busy}) begin
        miscompares++;
        $display("FAIL random c%0d: got %h/%b%b/%b want %h/%b%b/%b", i, bus.seg, bus.dig1,
                 bus.dig2, bus.busy, exp_seg, exp_dig1, exp_dig2, exp_busy);
      end
    end
    rst = 1'b0; bus.score_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.score_in = '0; bus.score_load = 1'b0; bus.seginv = 1'b0; bus.blank = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_42();
    test_clamp();
    test_seven();
    test_back_to_back();
    test_reset_and_blank();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
